ex_pipe_hazard_ctrl: RTL and testbench
======================================

// Module: ex_pipe_hazard_ctrl
// PURPOSE
//  Stall/flush controller for the 4-deep execute pipeline (ID/EX1, EX1/EX2, EX2/EX3, EX3/EX4 registers).
//  Tracks a per-stage scoreboard (valid, dest reg, RegWrite, MemRead, custom flag) for every instruction in EX1..EX4.
//  Detects non-forwardable RAW hazards and custom SAD unit occupancy. Drives PC/IF-ID hold and per-register bubble/flush.
//  Flushes younger stages when a jump/JR resolves in EX4.
// PARAMETERS
//  FWD_STAGE   3  lowest EX stage (1..4) whose non-load RegWrite result can be forwarded to ID consumers
//  CUSTOM_LAT  4  cycles the SAD/custom unit stays occupied after a custom op enters EX1 (1..15)
// PORTS
//  Clk            in   1  clock, rising edge
//  Reset          in   1  synchronous, active-high
//  ID_Valid       in   1  ID stage holds a real instruction
//  ID_rs          in   5  source register rs of ID instruction
//  ID_rt          in   5  source register rt of ID instruction
//  ID_UsesRs      in   1  ID instruction reads rs
//  ID_UsesRt      in   1  ID instruction reads rt
//  ID_Dst         in   5  destination register (post-RegDst mux) of ID instruction
//  ID_RegWrite    in   1  ID instruction writes the register file
//  ID_MemRead     in   1  ID instruction is a load
//  ID_Custom      in   1  ID instruction is a custom SAD-unit op
//  Redirect_EX4   in   1  jump/JR/jal in EX4 is redirecting the PC this cycle
//  PCWrite        out  1  1 = PC may update
//  IF_ID_Write    out  1  1 = IF/ID register may load
//  IF_ID_Flush    out  1  1 = IF/ID loads a bubble
//  ID_EX1_Flush   out  1  1 = ID/EX1 loads a bubble (all controls 0)
//  EX1_EX2_Flush  out  1  1 = EX1/EX2 loads a bubble
//  EX2_EX3_Flush  out  1  1 = EX2/EX3 loads a bubble
//  EX3_EX4_Flush  out  1  1 = EX3/EX4 loads a bubble
//  Stall          out  1  hazard stall active this cycle
//  SadBusy        out  1  custom-unit occupancy counter non-zero
// BEHAVIOUR
//  State: slot[1..4] = {v, dst[4:0], rw, mr, cu}; busy_cnt[3:0]. All outputs combinational from state and inputs.
//  Reset (sync): all slot.v=0, busy_cnt=0. Reset wins over all other events, including mid-stall and mid-redirect.
//  Empty-pipeline outputs (incl. the cycle after reset): PCWrite=1, IF_ID_Write=1, all Flush=0, Stall=0, SadBusy=0.
//  Source match: src s is checked only if its Uses bit=1 and s!=0. $0 never causes a hazard.
//  RAW hazard: for any k in 1..4, slot[k].v & rw & dst==s & (mr | k<FWD_STAGE).
//    Loads are never forwardable from inside EX1..EX4.
//  Custom hazard: ID_Valid & ID_Custom & busy_cnt>1. Issue is allowed when busy_cnt<=1.
//    This gives back-to-back custom issue spacing of exactly CUSTOM_LAT cycles.
//  Stall = ID_Valid & (RAW | custom hazard) & !Redirect_EX4.
//    Effect: PCWrite=0, IF_ID_Write=0, ID_EX1_Flush=1.
//  Redirect_EX4=1 has priority over Stall.
//    Effect: PCWrite=1, IF_ID_Flush=1, ID_EX1_Flush=1, EX1_EX2_Flush=1, EX2_EX3_Flush=1, EX3_EX4_Flush=1.
//    The EX4 instruction itself retires normally.
//  Scoreboard shift every cycle (there is no downstream stall):
//    slot[4]<=slot[3]; slot[3]<=slot[2]; slot[2]<=slot[1].
//    slot[1]<=ID fields with v=ID_Valid, or v=0 if Stall or Redirect_EX4.
//  On Redirect_EX4: slot[2..4] next v=0, and slot[1] next v=0.
//  busy_cnt next-state priority:
//    1) Redirect_EX4 and the custom op owning the counter is in slot[1..3]: busy_cnt<=0.
//    2) A custom op enters slot[1]: busy_cnt<=CUSTOM_LAT.
//    3) busy_cnt!=0: busy_cnt<=busy_cnt-1.
//  Only one custom op may own the counter at a time; this is guaranteed by the custom hazard.
//  Counter ownership for rule 1 is identified by the cu bit in slot[1..3] while busy_cnt!=0.
//  SadBusy = (busy_cnt!=0).
//  Stall with ID_Valid=0 is never asserted. Both RAW and custom hazards in the same cycle give a single stall.
// TESTING
//  1) Reset, then lw $8 into ID, then add $9,$8,$8 -> 4 stall cycles (PCWrite=0, ID_EX1_Flush=1); add enters EX1 on cycle 5.
//  2) add $8 followed by sub $10,$8,$1 (FWD_STAGE=3) -> exactly 2 stall cycles; an $0 consumer after add $0 -> 0 stalls.
//  3) Two custom ops back-to-back -> second enters EX1 exactly 4 cycles after the first; SadBusy high for 4 cycles.
//  4) Redirect_EX4=1 while a load-use stall is active -> Stall=0, PCWrite=1, all 5 Flush=1; the next cycle has an empty scoreboard.
//  5) Custom op in EX2 when Redirect_EX4 fires -> busy_cnt=0 next cycle; a new custom op issues with no stall.
//  6) Reset asserted mid-stall with busy_cnt=3 -> the next cycle shows PCWrite=1, Stall=0, SadBusy=0.

Source files
------------

// File: rtl/ex_pipe_hazard_ctrl.sv
// Stall/flush controller for a 4-deep execute pipeline: scoreboards EX1..EX4, detects
// non-forwardable RAW and SAD-unit occupancy hazards, and flushes younger stages on an EX4 redirect.
module ex_pipe_hazard_ctrl #(
  parameter int FWD_STAGE  = 3,
  parameter int CUSTOM_LAT = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ID_Valid,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic [4:0] ID_Dst,
  input  logic       ID_RegWrite,
  input  logic       ID_MemRead,
  input  logic       ID_Custom,
  input  logic       Redirect_EX4,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX1_Flush,
  output logic       EX1_EX2_Flush,
  output logic       EX2_EX3_Flush,
  output logic       EX3_EX4_Flush,
  output logic       Stall,
  output logic       SadBusy
);

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
    logic       cu;
  } slot_t;

  slot_t      slot [1:4];
  logic [3:0] busy_cnt;
  logic       raw_hz;
  logic       cust_hz;
  logic       cu_issue;
  logic       cu_owner;

  function automatic slot_t kill(input slot_t s, input logic r);
    slot_t o;
    o   = s;
    o.v = s.v & ~r;
    return o;
  endfunction

  // A producer blocks the ID consumer if it is a load, or too young to forward from.
  always_comb begin
    raw_hz = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (slot[k].v && slot[k].rw && (slot[k].mr || k < FWD_STAGE)) begin
        if (ID_UsesRs && ID_rs != 5'd0 && slot[k].dst == ID_rs) raw_hz = 1'b1;
        if (ID_UsesRt && ID_rt != 5'd0 && slot[k].dst == ID_rt) raw_hz = 1'b1;
      end
    end
  end

  always_comb begin
    cust_hz       = ID_Custom && (busy_cnt > 4'd1);
    Stall         = ID_Valid && (raw_hz || cust_hz) && !Redirect_EX4;
    PCWrite       = Redirect_EX4 || !Stall;
    IF_ID_Write   = Redirect_EX4 || !Stall;
    IF_ID_Flush   = Redirect_EX4;
    ID_EX1_Flush  = Redirect_EX4 || Stall;
    EX1_EX2_Flush = Redirect_EX4;
    EX2_EX3_Flush = Redirect_EX4;
    EX3_EX4_Flush = Redirect_EX4;
    SadBusy       = (busy_cnt != 4'd0);
    cu_issue      = ID_Valid && ID_Custom && !Stall && !Redirect_EX4;
    cu_owner      = (slot[1].v && slot[1].cu) || (slot[2].v && slot[2].cu) ||
                    (slot[3].v && slot[3].cu);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 1; k <= 4; k++) slot[k] <= '0;
      busy_cnt <= 4'd0;
    end else begin
      slot[4] <= kill(slot[3], Redirect_EX4);
      slot[3] <= kill(slot[2], Redirect_EX4);
      slot[2] <= kill(slot[1], Redirect_EX4);
      slot[1] <= '{v:   ID_Valid && !Stall && !Redirect_EX4,
                   dst: ID_Dst,
                   rw:  ID_RegWrite,
                   mr:  ID_MemRead,
                   cu:  ID_Custom};
      // A flushed custom op releases the SAD unit immediately.
      if (Redirect_EX4 && cu_owner && busy_cnt != 4'd0)
        busy_cnt <= 4'd0;
      else if (cu_issue)
        busy_cnt <= 4'(CUSTOM_LAT);
      else if (busy_cnt != 4'd0)
        busy_cnt <= busy_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_ex_pipe_hazard_ctrl.sv
// Directed bench for ex_pipe_hazard_ctrl: load-use, forwarding window, SAD spacing, redirect and reset.
module tb_ex_pipe_hazard_ctrl;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead, ID_Custom;
  logic [4:0] ID_rs, ID_rt, ID_Dst;
  logic       Redirect_EX4;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX1_Flush;
  logic       EX1_EX2_Flush, EX2_EX3_Flush, EX3_EX4_Flush, Stall, SadBusy;
  logic [8:0] obs;
  int         tests = 0;
  int         fails = 0;

  localparam logic [8:0] IDLE_V  = 9'b110000000;
  localparam logic [8:0] STALL_V = 9'b000100010;

  always #5 Clk = ~Clk;

  ex_pipe_hazard_ctrl #(.FWD_STAGE(3), .CUSTOM_LAT(4)) dut (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Dst(ID_Dst),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_Custom(ID_Custom),
    .Redirect_EX4(Redirect_EX4), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX1_Flush(ID_EX1_Flush), .EX1_EX2_Flush(EX1_EX2_Flush),
    .EX2_EX3_Flush(EX2_EX3_Flush), .EX3_EX4_Flush(EX3_EX4_Flush), .Stall(Stall),
    .SadBusy(SadBusy)
  );

  assign obs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX1_Flush, EX1_EX2_Flush,
                EX2_EX3_Flush, EX3_EX4_Flush, Stall, SadBusy};

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic mr, input logic cu);
    ID_Valid = v; ID_rs = rs; ID_rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_Dst = dst; ID_RegWrite = rw; ID_MemRead = mr; ID_Custom = cu;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    Redirect_EX4 = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (6) cyc();
  endtask

  // Counts stalled cycles until the ID instruction may issue (bounded at 20).
  task automatic count_stalls(output int n);
    n = 0;
    #1;
    while (Stall && n < 20) begin
      n++;
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b1;
    cyc(); cyc();
    Reset = 1'b0;
    #1;
    tests++;
    if (obs !== IDLE_V) begin
      fails++; $display("FAIL reset_outputs: got %b want %b", obs, IDLE_V);
    end
  endtask

  task automatic test_load_use();
    int n;
    drain();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);   // lw $8
    #1;
    tests++;
    if (obs !== IDLE_V) begin
      fails++; $display("FAIL lw_issue: got %b want %b", obs, IDLE_V);
    end
    cyc();
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);   // add $9,$8,$8
    #1;
    tests++;
    if (obs !== STALL_V) begin
      fails++; $display("FAIL load_use_stall_outputs: got %b want %b", obs, STALL_V);
    end
    count_stalls(n);
    tests++;
    if (n !== 4) begin
      fails++; $display("FAIL load_use_stall_count: got %0d want 4", n);
    end
    tests++;
    if (PCWrite !== 1'b1) begin
      fails++; $display("FAIL load_use_release_pcwrite: got %b want 1", PCWrite);
    end
    cyc();
    idle();
  endtask

  task automatic test_forward();
    int n;
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);   // add $8
    cyc();
    set_id(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);  // sub $10,$8,$1
    count_stalls(n);
    tests++;
    if (n !== 2) begin
      fails++; $display("FAIL alu_raw_stall_count: got %0d want 2", n);
    end
    cyc();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);   // lw $0
    cyc();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // reads $0
    count_stalls(n);
    tests++;
    if (n !== 0) begin
      fails++; $display("FAIL reg0_no_hazard: got %0d want 0", n);
    end
    cyc();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);   // lw $8
    cyc();
    set_id(1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);   // fields name $8 but unused
    count_stalls(n);
    tests++;
    if (n !== 0) begin
      fails++; $display("FAIL unused_src_no_hazard: got %0d want 0", n);
    end
    set_id(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);   // bubble in ID
    #1;
    tests++;
    if (Stall !== 1'b0) begin
      fails++; $display("FAIL invalid_id_no_stall: got %b want 0", Stall);
    end
    cyc();
    idle();
  endtask

  task automatic test_custom();
    int n;
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);  // custom #1
    #1;
    tests++;
    if (obs !== IDLE_V) begin
      fails++; $display("FAIL custom_first_issue: got %b want %b", obs, IDLE_V);
    end
    cyc();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);  // custom #2
    count_stalls(n);
    tests++;
    if (n !== 3) begin
      fails++; $display("FAIL custom_spacing_stalls: got %0d want 3", n);
    end
    cyc();
    idle();
    n = 0;
    #1;
    while (SadBusy && n < 20) begin
      n++;
      @(posedge Clk);
      #2;
    end
    tests++;
    if (n !== 4) begin
      fails++; $display("FAIL sadbusy_cycles: got %0d want 4", n);
    end
  endtask

  task automatic test_redirect_stall();
    drain();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);   // lw $8
    cyc();
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    cyc();
    Redirect_EX4 = 1'b1;
    #1;
    tests++;
    if ((obs & 9'b101111111) !== 9'b101111100) begin
      fails++; $display("FAIL redirect_over_stall: got %b want %b (IF_ID_Write ignored)",
                        obs, 9'b101111100);
    end
    cyc();
    Redirect_EX4 = 1'b0;
    #1;
    tests++;
    if (obs !== IDLE_V) begin
      fails++; $display("FAIL redirect_empty_scoreboard: got %b want %b", obs, IDLE_V);
    end
    cyc();
    idle();
  endtask

  task automatic test_redirect_custom();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
    cyc();
    idle();
    cyc();
    Redirect_EX4 = 1'b1;
    #1;
    tests++;
    if (SadBusy !== 1'b1) begin
      fails++; $display("FAIL custom_ex2_busy: got %b want 1", SadBusy);
    end
    cyc();
    Redirect_EX4 = 1'b0;
    #1;
    tests++;
    if (SadBusy !== 1'b0) begin
      fails++; $display("FAIL redirect_clears_busy: got %b want 0", SadBusy);
    end
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    #1;
    tests++;
    if (Stall !== 1'b0) begin
      fails++; $display("FAIL custom_after_redirect_stall: got %b want 0", Stall);
    end
    cyc();
    idle();
    #1;
    tests++;
    if (SadBusy !== 1'b1) begin
      fails++; $display("FAIL custom_after_redirect_busy: got %b want 1", SadBusy);
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
    cyc();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    cyc();
    #1;
    tests++;
    if ({Stall, SadBusy} !== 2'b11) begin
      fails++; $display("FAIL pre_reset_stall: got %b want 11", {Stall, SadBusy});
    end
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    #1;
    tests++;
    if (obs !== IDLE_V) begin
      fails++; $display("FAIL reset_mid_stall: got %b want %b", obs, IDLE_V);
    end
    cyc();
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_forward();
    test_custom();
    test_redirect_stall();
    test_redirect_custom();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
